// File: rtl/aes_round_ctrl_pkg.sv
// Shared AES definitions: block/key widths, round count and the round
// sequencer state type. Also used by the round datapath and key schedule.
package aes_round_ctrl_pkg;

  localparam int unsigned AES_BLK_W = 128;
  localparam int unsigned AES128_NR = 10;
  localparam int unsigned RK_IDX_W  = 4;

  typedef logic [AES_BLK_W-1:0] aes_blk_t;
  typedef logic [RK_IDX_W-1:0]  rk_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_st_t;

  // Width of a down-counter that must hold the value lat (never narrower than 1).
  function automatic int unsigned lat_cnt_w(input int unsigned lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Bundle of the sequencer's stream, key-store and datapath signals.
// slave: the sequencer's view; master: the surrounding environment's view.
interface aes_round_ctrl_if;
  import aes_round_ctrl_pkg::*;

  // plaintext input stream
  logic     in_valid;
  logic     in_ready;
  aes_blk_t in_block;
  // round-key store
  rk_idx_t  rk_idx;
  aes_blk_t rk;
  // round datapath
  logic     rnd_start;
  aes_blk_t rnd_state;
  aes_blk_t rnd_key;
  logic     rnd_final;
  aes_blk_t rnd_out;
  // ciphertext output stream
  logic     out_valid;
  logic     out_ready;
  aes_blk_t out_block;
  // status
  logic     busy;

  modport slave (
    input  in_valid, in_block, rk, rnd_out, out_ready,
    output in_ready, rk_idx, rnd_start, rnd_state, rnd_key, rnd_final,
           out_valid, out_block, busy
  );

  modport master (
    output in_valid, in_block, rk, rnd_out, out_ready,
    input  in_ready, rk_idx, rnd_start, rnd_state, rnd_key, rnd_final,
           out_valid, out_block, busy
  );

endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer. Takes one plaintext at a time, does the
// initial AddRoundKey, then issues rounds 1..NR to a shared round datapath,
// waiting ROUND_LAT cycles per round, and finally offers the ciphertext.
module aes_round_ctrl
  import aes_round_ctrl_pkg::*;
#(
  parameter int unsigned NR        = AES128_NR,
  parameter int unsigned ROUND_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  aes_round_ctrl_if.slave  bus
);

  localparam int unsigned LAT_W = lat_cnt_w(ROUND_LAT);
  localparam rk_idx_t           NR_IDX   = RK_IDX_W'(NR);
  localparam rk_idx_t           IDX_ONE  = RK_IDX_W'(1);
  localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(ROUND_LAT);
  localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);

  ctrl_st_t         fsm_q, fsm_d;
  aes_blk_t         state_q, state_d;
  rk_idx_t          round_q, round_d;
  logic [LAT_W-1:0] lat_q, lat_d;

  logic    in_ready_q, in_ready_d;
  logic    out_valid_q, out_valid_d;
  logic    busy_q, busy_d;
  logic    rnd_start_q, rnd_start_d;
  logic    rnd_final_q, rnd_final_d;
  rk_idx_t rk_idx_q, rk_idx_d;
  logic    in_round;

  // Next-state, datapath registers and next values of the registered outputs.
  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    round_d     = round_q;
    lat_d       = lat_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    rnd_start_d = 1'b0;
    rnd_final_d = 1'b0;
    rk_idx_d    = '0;
    in_round    = 1'b0;

    unique case (fsm_q)
      ST_IDLE: begin
        // rk_idx is 0 here, so rk is the whitening key
        if (bus.in_valid) begin
          state_d = bus.in_block ^ bus.rk;
          round_d = IDX_ONE;
          fsm_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        lat_d = LAT_INIT;
        fsm_d = ST_WAIT;
      end
      ST_WAIT: begin
        lat_d = lat_q - LAT_ONE;
        if (lat_q == LAT_ONE) begin
          state_d = bus.rnd_out;
          if (round_q == NR_IDX) begin
            fsm_d = ST_DONE;
          end else begin
            round_d = round_q + IDX_ONE;
            fsm_d   = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          round_d = '0;
          fsm_d   = ST_IDLE;
        end
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they follow the state being entered.
    in_round    = (fsm_d == ST_ISSUE) || (fsm_d == ST_WAIT);
    in_ready_d  = (fsm_d == ST_IDLE);
    out_valid_d = (fsm_d == ST_DONE);
    busy_d      = (fsm_d != ST_IDLE);
    rnd_start_d = (fsm_d == ST_ISSUE);
    rnd_final_d = in_round && (round_d == NR_IDX);
    rk_idx_d    = in_round ? round_d : '0;
  end

  // State register and registered outputs; reset discards any block in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= ST_IDLE;
      state_q     <= '0;
      round_q     <= '0;
      lat_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rnd_start_q <= 1'b0;
      rnd_final_q <= 1'b0;
      rk_idx_q    <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      round_q     <= round_d;
      lat_q       <= lat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      rnd_start_q <= rnd_start_d;
      rnd_final_q <= rnd_final_d;
      rk_idx_q    <= rk_idx_d;
    end
  end

  // The round key is passed straight through from the key store.
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.rnd_start = rnd_start_q;
  assign bus.rnd_final = rnd_final_q;
  assign bus.rk_idx    = rk_idx_q;
  assign bus.rnd_state = state_q;
  assign bus.rnd_key   = bus.rk;
  assign bus.out_block = state_q;

  // Round counter never runs past the last round.
  a_round_range : assert property (@(posedge clk) disable iff (rst)
    round_q <= NR_IDX);

  // A round in flight always has cycles left to wait.
  a_wait_lat : assert property (@(posedge clk) disable iff (rst)
    (fsm_q == ST_WAIT) |-> (lat_q != '0));

  // Ciphertext does not move while the consumer stalls.
  a_out_hold : assert property (@(posedge clk) disable iff (rst)
    (out_valid_q && !bus.out_ready) |=> $stable(state_q));

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: two instances (ROUND_LAT 1 and 3), each with a
// behavioural round datapath and key store; results are compared with a
// byte-level AES-128 reference and FIPS-197 C.1.
module tb_aes_round_ctrl;
  import aes_round_ctrl_pkg::*;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_round_ctrl_if b1();
  aes_round_ctrl_if b3();

  aes_round_ctrl #(.NR(10), .ROUND_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
  aes_round_ctrl #(.NR(10), .ROUND_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));

  // ---------------- AES behavioural model ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic void init_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h01;
      if (v == 0) inv = 8'h00;
      else for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
      sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                            input logic fin);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] t0, t1, t2, t3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) b[rr+4*c] = a[rr + 4*((c+rr)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        t0 = b[4*c]; t1 = b[4*c+1]; t2 = b[4*c+2]; t3 = b[4*c+3];
        b[4*c]   = gmul(t0, 8'd2) ^ gmul(t1, 8'd3) ^ t2 ^ t3;
        b[4*c+1] = t0 ^ gmul(t1, 8'd2) ^ gmul(t2, 8'd3) ^ t3;
        b[4*c+2] = t0 ^ t1 ^ gmul(t2, 8'd2) ^ gmul(t3, 8'd3);
        b[4*c+3] = gmul(t0, 8'd3) ^ t1 ^ t2 ^ gmul(t3, 8'd2);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r ^ k;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ key;
    for (int r = 1; r <= 10; r++) s = round_fn(s, round_key(key, r), r == 10);
    return s;
  endfunction

  // ---------------- key stores and round datapaths ----------------
  logic [127:0] rks1 [11];
  logic [127:0] rks3 [11];
  logic [127:0] dp1;
  logic [127:0] dp3 [3];

  assign b1.rk = (b1.rk_idx <= 4'd10) ? rks1[b1.rk_idx] : '0;
  assign b3.rk = (b3.rk_idx <= 4'd10) ? rks3[b3.rk_idx] : '0;

  always @(posedge clk) dp1 <= round_fn(b1.rnd_state, b1.rnd_key, b1.rnd_final);
  always @(posedge clk) begin
    dp3[0] <= round_fn(b3.rnd_state, b3.rnd_key, b3.rnd_final);
    dp3[1] <= dp3[0];
    dp3[2] <= dp3[1];
  end
  assign b1.rnd_out = dp1;
  assign b3.rnd_out = dp3[2];

  // ---------------- checking ----------------
  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Monitor for instance 1: per-round controls, handshakes, hold rules.
  logic [3:0]   st_idx [$];
  logic         st_fin [$];
  logic [127:0] st_state [$];
  int unsigned  acc_cyc [$];
  logic [127:0] out_q [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (b1.rnd_start) begin
        st_idx.push_back(b1.rk_idx);
        st_fin.push_back(b1.rnd_final);
        st_state.push_back(b1.rnd_state);
      end else if (b1.busy && !b1.out_valid && st_idx.size() > 0) begin
        chk_eq("hold_rk_idx", 128'(b1.rk_idx), 128'(st_idx[$]));
        chk_eq("hold_final", 128'(b1.rnd_final), 128'(st_fin[$]));
        chk_eq("hold_state", b1.rnd_state, st_state[$]);
      end
      if (b1.out_valid || b1.in_ready) chk_eq("idle_done_rk_idx", 128'(b1.rk_idx), 128'(0));
      if (b1.in_valid && b1.in_ready) acc_cyc.push_back(cyc);
      if (b1.out_valid && b1.out_ready) out_q.push_back(b1.out_block);
    end
  end

  task automatic chk_reset_outs(input string tag);
    chk_eq({tag, "_in_ready"},  128'(b1.in_ready),  128'(1));
    chk_eq({tag, "_out_valid"}, 128'(b1.out_valid), 128'(0));
    chk_eq({tag, "_rnd_start"}, 128'(b1.rnd_start), 128'(0));
    chk_eq({tag, "_rnd_final"}, 128'(b1.rnd_final), 128'(0));
    chk_eq({tag, "_busy"},      128'(b1.busy),      128'(0));
    chk_eq({tag, "_out_block"}, b1.out_block,       128'(0));
    chk_eq({tag, "_rnd_state"}, b1.rnd_state,       128'(0));
    chk_eq({tag, "_rk_idx"},    128'(b1.rk_idx),    128'(0));
  endtask

  task automatic load_keys1(input logic [127:0] key);
    for (int r = 0; r < 11; r++) rks1[r] = round_key(key, r);
  endtask

  // Offer a block to instance 1 and wait (bounded) for its acceptance edge.
  task automatic offer1(input logic [127:0] pt);
    bit seen;
    int n;
    seen = 1'b0; n = 0;
    b1.in_block = pt;
    b1.in_valid = 1'b1;
    while (!seen && n < 100) begin
      seen = b1.in_ready;
      @(posedge clk); #1;
      n++;
    end
    b1.in_valid = 1'b0;
    chk_eq("accept", 128'(seen), 128'(1));
  endtask

  // One full block on instance 1, with a stall of `stall` cycles on output.
  task automatic run_block1(input logic [127:0] key, input logic [127:0] pt,
                            input int stall, output logic [127:0] ct);
    logic [127:0] held;
    int n;
    load_keys1(key);
    st_idx.delete(); st_fin.delete(); st_state.delete();
    offer1(pt);
    n = 0;
    while (!b1.out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk_eq("ov_latency", 128'(n), 128'(20));
    ct = b1.out_block;
    chk_eq("ct_model", ct, aes_ref(key, pt));
    held = b1.out_block;
    repeat (stall) begin
      @(posedge clk); #1;
      chk_eq("stall_block", b1.out_block, held);
      chk_eq("stall_in_ready", 128'(b1.in_ready), 128'(0));
      chk_eq("stall_out_valid", 128'(b1.out_valid), 128'(1));
    end
    b1.out_ready = 1'b1;
    @(posedge clk); #1;
    b1.out_ready = 1'b0;
    chk_eq("post_out_valid", 128'(b1.out_valid), 128'(0));
    chk_eq("post_in_ready", 128'(b1.in_ready), 128'(1));
    chk_eq("post_busy", 128'(b1.busy), 128'(0));
    chk_eq("n_starts", 128'(st_idx.size()), 128'(10));
    for (int i = 0; i < st_idx.size(); i++) begin
      chk_eq("start_rk_idx", 128'(st_idx[i]), 128'(i + 1));
      chk_eq("start_final", 128'(st_fin[i]), 128'(i == 9));
    end
    if (st_state.size() > 0) chk_eq("r1_state", st_state[0], pt ^ key);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] ct, key, pt1, pt2;
    int n;
    bit seen;
    rst = 1'b1;
    b1.in_valid = 1'b0; b1.in_block = '0; b1.out_ready = 1'b0;
    b3.in_valid = 1'b0; b3.in_block = '0; b3.out_ready = 1'b0;
    for (int r = 0; r < 11; r++) begin rks1[r] = '0; rks3[r] = '0; end
    init_sbox();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("rst0");
    rst = 1'b0;
    @(posedge clk); #1;

    // FIPS-197 C.1 with per-round controls and a 7-cycle output stall
    run_block1(C1_KEY, C1_PT, 7, ct);
    chk_eq("c1_ct", ct, C1_CT);

    // Two back-to-back blocks, in_valid and out_ready held high
    key = {$urandom(), $urandom(), $urandom(), $urandom()};
    pt1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    pt2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    load_keys1(key);
    acc_cyc.delete(); out_q.delete();
    b1.out_ready = 1'b1; b1.in_block = pt1; b1.in_valid = 1'b1;
    n = 0;
    while (acc_cyc.size() < 1 && n < 100) begin @(posedge clk); #1; n++; end
    b1.in_block = pt2;
    n = 0;
    while (acc_cyc.size() < 2 && n < 100) begin @(posedge clk); #1; n++; end
    b1.in_valid = 1'b0;
    n = 0;
    while (out_q.size() < 2 && n < 100) begin @(posedge clk); #1; n++; end
    b1.out_ready = 1'b0;
    chk_eq("b2b_accepts", 128'(acc_cyc.size()), 128'(2));
    chk_eq("b2b_outputs", 128'(out_q.size()), 128'(2));
    if (acc_cyc.size() >= 2) chk_eq("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'(22));
    if (out_q.size() >= 2) begin
      chk_eq("b2b_ct1", out_q[0], aes_ref(key, pt1));
      chk_eq("b2b_ct2", out_q[1], aes_ref(key, pt2));
    end

    // Reset during round 5 WAIT, then a clean C.1 run
    load_keys1(C1_KEY);
    offer1(C1_PT);
    n = 0;
    while (!(b1.rk_idx == 4'd5 && b1.busy && !b1.rnd_start) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk_eq("reach_r5_wait", 128'(b1.rk_idx), 128'(5));
    #2 rst = 1'b1;
    #1 chk_reset_outs("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_block1(C1_KEY, C1_PT, 0, ct);
    chk_eq("c1_after_rst", ct, C1_CT);

    // Random blocks with random output stalls
    for (int i = 0; i < 5; i++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt1 = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_block1(key, pt1, int'($urandom_range(0, 4)), ct);
    end

    // ROUND_LAT = 3 instance on C.1
    for (int r = 0; r < 11; r++) rks3[r] = round_key(C1_KEY, r);
    b3.in_block = C1_PT; b3.in_valid = 1'b1;
    seen = 1'b0; n = 0;
    while (!seen && n < 100) begin
      seen = b3.in_ready;
      @(posedge clk); #1;
      n++;
    end
    b3.in_valid = 1'b0;
    chk_eq("lat3_accept", 128'(seen), 128'(1));
    n = 0;
    while (!b3.out_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk_eq("lat3_latency", 128'(n), 128'(40));
    chk_eq("lat3_ct", b3.out_block, C1_CT);
    b3.out_ready = 1'b1;
    @(posedge clk); #1;
    b3.out_ready = 1'b0;
    chk_eq("lat3_idle", 128'(b3.in_ready), 128'(1));
    chk_eq("lat3_out_valid", 128'(b3.out_valid), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
